// File: rtl/hd_sender.sv
// Purpose: buffers source words in a DEPTH-entry FIFO and presents them downstream through a registered output stage.
// Latency: 2 cycles minimum from source push to pipe_valid; one word per cycle sustained with pipe_ready held high.
// Backpressure: src_ready drops when the FIFO is full; pipe_data/pipe_valid hold while pipe_valid && !pipe_ready.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   src_data/valid/ready     source-side valid/ready handshake
//   flush                    synchronous discard of all buffered words (output register included)
//   pipe_data/valid/ready    downstream valid/ready handshake
//   fifo_level               FIFO occupancy, output register not included
//   xfer_count               completed downstream transfers, wrapping
module hd_sender #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic                     flush,
    input  logic                     pipe_ready,
    output logic [DATA_WIDTH-1:0]    pipe_data,
    output logic                     pipe_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]     xfer_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [LW-1:0]        LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]        LVL_FULL = LW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic                  pipe_valid_q, pipe_valid_d;
    logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;

    logic push;
    logic load;
    logic xfer;

    // src_ready looks only at registered occupancy: a full FIFO stays
    // closed for the cycle of a simultaneous load (no lookahead).
    assign src_ready = (level_q != LVL_FULL);

    assign push = src_valid && src_ready;
    assign xfer = pipe_valid_q && pipe_ready;
    // Load decision uses the occupancy before this edge's push, so a word
    // never bypasses the FIFO storage.
    assign load = (!pipe_valid_q || pipe_ready) && (level_q != '0);

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        pipe_data_d  = pipe_data_q;
        pipe_valid_d = pipe_valid_q;
        xfer_count_d = xfer_count_q;

        // Downstream has already captured a word at a flush edge, so the
        // transfer is counted regardless of flush.
        if (xfer) begin
            xfer_count_d = xfer_count_q + CNT_ONE;
        end

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            pipe_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = src_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end

            if (load) begin
                pipe_data_d  = mem_q[rd_ptr_q];
                pipe_valid_d = 1'b1;
                rd_ptr_d     = rd_ptr_q + PTR_ONE;
            end else if (xfer) begin
                // Word consumed with nothing behind it: drop valid, keep data.
                pipe_valid_d = 1'b0;
            end

            case ({push, load})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pipe_data_q  <= '0;
            pipe_valid_q <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign pipe_data  = pipe_data_q;
    assign pipe_valid = pipe_valid_q;
    assign fifo_level = level_q;
    assign xfer_count = xfer_count_q;

endmodule
